// File: rtl/dft_peak_search.sv
// dft_peak_search
// Scans a finished DFT frame for its strongest bin. The frame is captured on
// valid_i, then one bin per cycle is reduced to a power value. A running
// maximum of those powers is kept, and the winner is reported with a
// single-cycle valid_o pulse.
//
// Optional feature: define DFT_PEAK_THRESH_EN to add the thresh_i input and
// the detected_o output. detected_o reports whether the reported peak power
// is strictly above thresh_i.
//
// Ports
//   clk_i       sole clock, rising edge
//   rst_i       asynchronous, active-high reset
//   valid_i     one-cycle pulse; A_real_i/A_imag_i hold a finished frame
//   A_real_i    NUM_BINS signed words of ACCUM_WIDTH bits (bin 0 in the LSBs)
//   A_imag_i    NUM_BINS signed words of ACCUM_WIDTH bits (bin 0 in the LSBs)
//   thresh_i    (DFT_PEAK_THRESH_EN) unsigned power threshold
//   peak_idx_o  index of the strongest bin (lowest index wins a tie)
//   peak_pow_o  unsigned power of that bin
//   valid_o     one-cycle pulse; peak_idx_o/peak_pow_o are new
//   busy_o      a captured frame has not been reported yet
//   drop_o      one-cycle pulse; a valid_i arrived while busy and was ignored
//   detected_o  (DFT_PEAK_THRESH_EN) peak_pow_o > thresh_i, updated with valid_o
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a frame; valid_i captures it
// SCAN  | one bin per cycle, ascending from 0, tracking the running max
// DONE  | publishes the running max; valid_o rises on the next cycle
module dft_peak_search #(
    parameter  int ACCUM_WIDTH = 48,
    parameter  int NUM_BINS    = 24,
    parameter  int MAG_SHIFT   = 16,
    parameter  int IDX_WIDTH   = $clog2(NUM_BINS),
    localparam int MAG_WIDTH   = ACCUM_WIDTH - MAG_SHIFT,
    localparam int POW_WIDTH   = 2 * MAG_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            valid_i,
    input  logic [ACCUM_WIDTH*NUM_BINS-1:0] A_real_i,
    input  logic [ACCUM_WIDTH*NUM_BINS-1:0] A_imag_i,
`ifdef DFT_PEAK_THRESH_EN
    input  logic [POW_WIDTH-1:0]            thresh_i,
    output logic                            detected_o,
`endif
    output logic [IDX_WIDTH-1:0]            peak_idx_o,
    output logic [POW_WIDTH-1:0]            peak_pow_o,
    output logic                            valid_o,
    output logic                            busy_o,
    output logic                            drop_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ACCUM_WIDTH*NUM_BINS-1:0] frame_re;
    logic [ACCUM_WIDTH*NUM_BINS-1:0] frame_im;
    logic [IDX_WIDTH-1:0]            bin_cnt;
    logic                            last_bin;
    logic                            capture;

    logic [ACCUM_WIDTH-1:0]          cur_re;
    logic [ACCUM_WIDTH-1:0]          cur_im;
    logic signed [MAG_WIDTH-1:0]     mag_re;
    logic signed [MAG_WIDTH-1:0]     mag_im;
    logic signed [POW_WIDTH-1:0]     sq_re;
    logic signed [POW_WIDTH-1:0]     sq_im;
    logic [POW_WIDTH-1:0]            pow;

    logic [POW_WIDTH-1:0]            run_max;
    logic [IDX_WIDTH-1:0]            run_idx;

    assign last_bin = (bin_cnt == IDX_WIDTH'(NUM_BINS - 1));
    assign capture  = (state == IDLE) && valid_i;
    assign busy_o   = (state != IDLE);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (valid_i)  state_nxt = SCAN;
            SCAN: if (last_bin) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The frame is held so that the source may change its accumulators
    // while the scan is in progress. It needs no reset: it is only read
    // after a capture.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            frame_re <= A_real_i;
            frame_im <= A_imag_i;
        end
    end

    assign cur_re = frame_re[int'(bin_cnt) * ACCUM_WIDTH +: ACCUM_WIDTH];
    assign cur_im = frame_im[int'(bin_cnt) * ACCUM_WIDTH +: ACCUM_WIDTH];

    // Taking the upper bits is the arithmetic right shift truncated to
    // MAG_WIDTH, so the sign is preserved.
    assign mag_re = cur_re[ACCUM_WIDTH-1:MAG_SHIFT];
    assign mag_im = cur_im[ACCUM_WIDTH-1:MAG_SHIFT];

    // Each square is at most 2^(POW_WIDTH-2), which happens at the most
    // negative input. The sum therefore fits in POW_WIDTH unsigned bits.
    assign sq_re = mag_re * mag_re;
    assign sq_im = mag_im * mag_im;
    assign pow   = $unsigned(sq_re) + $unsigned(sq_im);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_cnt    <= '0;
            run_max    <= '0;
            run_idx    <= '0;
            peak_idx_o <= '0;
            peak_pow_o <= '0;
            valid_o    <= 1'b0;
            drop_o     <= 1'b0;
`ifdef DFT_PEAK_THRESH_EN
            detected_o <= 1'b0;
`endif
        end else begin
            valid_o <= 1'b0;
            drop_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        bin_cnt <= '0;
                    end
                end
                SCAN: begin
                    drop_o <= valid_i;
                    // Bin 0 seeds the max. After that, only a strictly
                    // larger power replaces it, so ties keep the lower index.
                    if (bin_cnt == '0 || pow > run_max) begin
                        run_max <= pow;
                        run_idx <= bin_cnt;
                    end
                    bin_cnt <= last_bin ? '0 : bin_cnt + 1'b1;
                end
                DONE: begin
                    drop_o     <= valid_i;
                    valid_o    <= 1'b1;
                    peak_idx_o <= run_idx;
                    peak_pow_o <= run_max;
`ifdef DFT_PEAK_THRESH_EN
                    detected_o <= (run_max > thresh_i);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
